// File: rtl/vending_machine_param.sv
// vending_machine_param
//   Two-coin, two-item vending controller that accumulates credit. A session
//   ends with either one vended item or a cancel. Any credit left at the end
//   of a session is paid back one CHANGE_COIN pulse at a time. Coins that would
//   push credit above MAX_CREDIT are rejected, as are invalid coin codes and
//   coins that arrive while the machine is busy.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   money        00 none, 01 COIN_A, 10 COIN_B, 11 invalid (one-cycle pulse)
//   select       00 none, 01 item A, 10 item B, 11 cancel (one-cycle pulse)
//   item         one-cycle pulse carrying the code of the vended item
//   change       one pulse per CHANGE_COIN returned
//   coin_reject  one-cycle pulse: the coin was not credited
//   deny         one-cycle pulse: selection refused, insufficient credit
//   credit       current credit
//   busy         high while vending or refunding
//
// All outputs are registered. An input sampled at one edge appears on the
// outputs after that edge.
module vending_machine_param #(
  parameter int CREDIT_W    = 8,
  parameter int COIN_A      = 10,
  parameter int COIN_B      = 50,
  parameter int PRICE_A     = 20,
  parameter int PRICE_B     = 50,
  parameter int MAX_CREDIT  = 150,
  parameter int CHANGE_COIN = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          money,
  input  logic [1:0]          select,
  output logic [1:0]          item,
  output logic                change,
  output logic                coin_reject,
  output logic                deny,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // One extra bit so that credit + coin can be compared against the ceiling
  // without wrapping.
  localparam int SUM_W = CREDIT_W + 1;

  // A bad configuration stops elaboration instead of producing a machine
  // that strands fractional change or wraps its credit register.
  if (CHANGE_COIN <= 0 || MAX_CREDIT >= (1 << CREDIT_W) ||
      (COIN_A % CHANGE_COIN) != 0 || (COIN_B % CHANGE_COIN) != 0 ||
      (PRICE_A % CHANGE_COIN) != 0 || (PRICE_B % CHANGE_COIN) != 0 ||
      (MAX_CREDIT % CHANGE_COIN) != 0) begin : g_bad_config
    $error("vending_machine_param: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, REFUND} state_t;

  state_t              state_reg;
  logic [CREDIT_W-1:0] credit_reg;
  logic [1:0]          item_reg;
  logic                change_reg;
  logic                coin_reject_reg;
  logic                deny_reg;
  logic                busy_reg;

  logic [SUM_W-1:0]    credit_ext;
  logic [SUM_W-1:0]    coin_sum     [2];
  logic                coin_fits    [2];
  logic                can_buy      [2];
  logic [CREDIT_W-1:0] credit_after [2];

  assign credit_ext = {1'b0, credit_reg};

  // Index 0 serves code 01 (coin A / item A) and index 1 serves code 10, so
  // bit 1 of a valid money/select code selects the entry.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_code
    localparam int COIN_V  = (gi == 0) ? COIN_A : COIN_B;
    localparam int PRICE_V = (gi == 0) ? PRICE_A : PRICE_B;

    assign coin_sum[gi]     = credit_ext + SUM_W'(COIN_V);
    assign coin_fits[gi]    = coin_sum[gi] <= SUM_W'(MAX_CREDIT);
    assign can_buy[gi]      = credit_ext >= SUM_W'(PRICE_V);
    assign credit_after[gi] = credit_reg - CREDIT_W'(PRICE_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      credit_reg      <= '0;
      item_reg        <= 2'b00;
      change_reg      <= 1'b0;
      coin_reject_reg <= 1'b0;
      deny_reg        <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      item_reg        <= 2'b00;
      change_reg      <= 1'b0;
      coin_reject_reg <= 1'b0;
      deny_reg        <= 1'b0;

      case (state_reg)
        IDLE, CREDIT: begin
          // A coin is credited only on its own; with a simultaneous select
          // it goes back so the selection sees the pre-coin credit.
          if (money != 2'b00) begin
            if (money == 2'b11 || select != 2'b00) begin
              coin_reject_reg <= 1'b1;
            end else if (coin_fits[money[1]]) begin
              credit_reg <= coin_sum[money[1]][CREDIT_W-1:0];
              state_reg  <= CREDIT;
            end else begin
              coin_reject_reg <= 1'b1;
            end
          end

          if (select == 2'b01 || select == 2'b10) begin
            if (can_buy[select[1]]) begin
              state_reg  <= VEND;
              busy_reg   <= 1'b1;
              item_reg   <= select;
              credit_reg <= credit_after[select[1]];
            end else begin
              deny_reg <= 1'b1;
            end
          end else if (select == 2'b11 && credit_reg != '0) begin
            state_reg <= REFUND;
            busy_reg  <= 1'b1;
          end
        end

        VEND: begin
          coin_reject_reg <= (money != 2'b00);
          // One item per session: any remainder is paid back.
          if (credit_reg != '0) begin
            state_reg <= REFUND;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end

        REFUND: begin
          coin_reject_reg <= (money != 2'b00);
          change_reg      <= 1'b1;
          // The last pulse leaves with credit reaching zero. The lower-or-equal
          // test keeps credit from ever going negative.
          if (credit_ext <= SUM_W'(CHANGE_COIN)) begin
            credit_reg <= '0;
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
          end else begin
            credit_reg <= credit_reg - CREDIT_W'(CHANGE_COIN);
          end
        end
      endcase
    end
  end

  assign item        = item_reg;
  assign change      = change_reg;
  assign coin_reject = coin_reject_reg;
  assign deny        = deny_reg;
  assign credit      = credit_reg;
  assign busy        = busy_reg;

endmodule
